// File: rtl/pipelined_carry_adder.sv
// -----------------------------------------------------------------------------
// pipelined_carry_adder
//
// Purpose:
//    Adder/subtractor split into STAGES carry-pipelined slices. Each stage
//    ripple-adds one CW-bit slice using the carry registered by the stage
//    before it. Operands travel down the pipe next to the partial sum so that
//    every operation's slices stay aligned. Valid/ready handshake on both
//    sides. One result per cycle, and latency is exactly STAGES cycles.
//
// Parameters:
//    WIDTH   operand width in bits (>= 1)
//    STAGES  number of pipeline stages (1 .. WIDTH); the last slice must be
//            at least one bit wide
//
// Ports:
//    clk      in   clock, rising edge
//    rst      in   synchronous active-high reset
//    a, b     in   operands, WIDTH bits
//    i_sub    in   0 = a+b, 1 = a-b (sampled with the operands)
//    i_valid  in   operands valid
//    o_ready  out  input accepted this cycle if i_valid is high
//    o_sum    out  WIDTH+1 bit result, bit WIDTH = raw carry-out
//                  (for subtract: 1 = no borrow)
//    o_ovf    out  two's-complement overflow of the result
//    o_valid  out  o_sum/o_ovf valid
//    i_ready  in   downstream accepts the output this cycle
// -----------------------------------------------------------------------------
module pipelined_carry_adder #(
   parameter int WIDTH  = 10,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             i_sub,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH:0]   o_sum,
   output logic             o_ovf,
   output logic             o_valid,
   input  logic             i_ready
);

   localparam int CW   = (WIDTH + STAGES - 1) / STAGES;
   localparam int LAST = STAGES - 1;

   // Ripple-add bits [lo, hi) of the operands on top of an existing partial
   // sum. Returns {carry into bit WIDTH-1, carry out of the slice, new sum}.
   // The carry into the MSB is only meaningful for the slice that owns the MSB.
   function automatic logic [WIDTH+1:0] f_slice_add(
      input logic [WIDTH-1:0] i_av,
      input logic [WIDTH-1:0] i_bv,
      input logic [WIDTH-1:0] i_sv,
      input logic             i_cin,
      input int               i_lo,
      input int               i_hi
   );
      logic [WIDTH-1:0] w_s;
      logic             w_c;
      logic             w_cmsb;
      w_s    = i_sv;
      w_c    = i_cin;
      w_cmsb = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if ((i >= i_lo) && (i < i_hi)) begin
            if (i == WIDTH - 1) begin
               w_cmsb = w_c;
            end else begin
               w_cmsb = w_cmsb;
            end
            w_s[i] = i_av[i] ^ i_bv[i] ^ w_c;
            w_c    = (i_av[i] & i_bv[i]) | (i_av[i] & w_c) | (i_bv[i] & w_c);
         end else begin
            w_s[i] = w_s[i];
         end
      end
      return {w_cmsb, w_c, w_s};
   endfunction

   // Per-stage state. r_b holds B already inverted for subtraction, so the
   // mode bit is fully represented by r_b plus the stage-0 carry-in and
   // needs no separate copy further down the pipe.
   logic [WIDTH-1:0] r_a     [STAGES];
   logic [WIDTH-1:0] r_b     [STAGES];
   logic [WIDTH-1:0] r_sum   [STAGES];
   logic             r_c     [STAGES];
   logic             r_valid [STAGES];
   logic             r_ovf;

   // Inputs feeding each stage register (stage 0 from the ports).
   logic [WIDTH-1:0] w_a_in  [STAGES];
   logic [WIDTH-1:0] w_b_in  [STAGES];
   logic [WIDTH-1:0] w_s_in  [STAGES];
   logic             w_c_in  [STAGES];
   logic             w_v_in  [STAGES];
   logic [WIDTH+1:0] w_res   [STAGES];
   logic             w_en;

   // The whole pipe moves together; it stalls only when a finished result
   // is waiting and the downstream is not taking it.
   assign w_en    = !r_valid[LAST] || i_ready;
   // Reset always leaves the pipe empty, so it is safe to advertise ready.
   assign o_ready = w_en | rst;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign w_a_in[k] = a;
         assign w_b_in[k] = b ^ {WIDTH{i_sub}};
         assign w_s_in[k] = '0;
         assign w_c_in[k] = i_sub;
         assign w_v_in[k] = i_valid;
      end else begin : g_body
         assign w_a_in[k] = r_a[k-1];
         assign w_b_in[k] = r_b[k-1];
         assign w_s_in[k] = r_sum[k-1];
         assign w_c_in[k] = r_c[k-1];
         assign w_v_in[k] = r_valid[k-1];
      end
      // Last slice takes whatever bits remain above the earlier full slices.
      assign w_res[k] = f_slice_add(w_a_in[k], w_b_in[k], w_s_in[k], w_c_in[k],
                                    k * CW, (k == LAST) ? WIDTH : (k + 1) * CW);
   end

   // Pipeline registers: reset clears everything, otherwise advance on enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_a[k]     <= '0;
            r_b[k]     <= '0;
            r_sum[k]   <= '0;
            r_c[k]     <= 1'b0;
            r_valid[k] <= 1'b0;
         end
         r_ovf <= 1'b0;
      end else if (w_en) begin
         for (int k = 0; k < STAGES; k++) begin
            r_a[k]     <= w_a_in[k];
            r_b[k]     <= w_b_in[k];
            r_sum[k]   <= w_res[k][WIDTH-1:0];
            r_c[k]     <= w_res[k][WIDTH];
            r_valid[k] <= w_v_in[k];
         end
         // Overflow = carry into MSB xor carry out of MSB (both from last slice).
         r_ovf <= w_res[LAST][WIDTH+1] ^ w_res[LAST][WIDTH];
      end
   end

   assign o_sum   = {r_c[LAST], r_sum[LAST]};
   assign o_ovf   = r_ovf;
   assign o_valid = r_valid[LAST];

endmodule

// File: doc/pipelined_carry_adder.md
PIPELINED_CARRY_ADDER -- requirements
Module: pipelined_carry_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, giving the operand width in bits (legal range WIDTH >= 1).
REQ-002 The block SHALL have parameter STAGES, default 2, giving the number of pipeline stages (legal range 1 <= STAGES <= WIDTH).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The block SHALL have port i_sub, input, 1 bit: 0 = A+B, 1 = A-B; sampled together with the operands.
REQ-009 The block SHALL have port i_valid, input, 1 bit: the operands are valid.
REQ-010 The block SHALL have port o_ready, output, 1 bit: the block can accept an input this cycle.
REQ-011 The block SHALL have port o_sum, output, WIDTH+1 bits: the result; bit WIDTH is the carry-out.
REQ-012 The block SHALL have port o_ovf, output, 1 bit: two's-complement signed overflow of the result.
REQ-013 The block SHALL have port o_valid, output, 1 bit: o_sum and o_ovf are valid.
REQ-014 The block SHALL have port i_ready, input, 1 bit: the downstream accepts the output this cycle.

Function
REQ-015 The block SHALL split the operands into STAGES slices of CW = ceil(WIDTH/STAGES) bits, LSB first; the last slice SHALL hold the remaining WIDTH-(STAGES-1)*CW bits and SHALL be at least 1 bit wide.
REQ-016 Stage k SHALL ripple-add slice k using the carry registered from stage k-1; stage 0 carry-in SHALL be i_sub.
REQ-017 Subtraction SHALL be computed as A + ~B + 1, where inversion of B is applied at input capture.
REQ-018 Unused upper slices of A, B and the mode bit SHALL be delay-registered alongside the partial result so that each operation's slices stay aligned.
REQ-019 o_sum[WIDTH-1:0] SHALL equal (A ± B) mod 2^WIDTH.
REQ-020 o_sum[WIDTH] SHALL be the raw carry-out: for add it is the carry; for subtract, 1 means no borrow (A >= B unsigned).
REQ-021 o_ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-022 Latency SHALL be exactly STAGES cycles from an accepted input to o_valid, given i_ready held high.
REQ-023 Throughput SHALL be one operation per cycle, with no bubbles inserted.
REQ-024 Pipeline enable SHALL be en = !o_valid || i_ready; every stage register, including valid bits, SHALL advance only when en = 1.
REQ-025 o_ready SHALL equal en, combinationally.
REQ-026 An input SHALL be accepted only when i_valid && o_ready; when i_valid = 0 with en = 1, a bubble (valid = 0) SHALL enter stage 0.
REQ-027 While o_valid && !i_ready, o_sum, o_ovf and o_valid SHALL hold stable and no input SHALL be accepted.
REQ-028 Per-stage valid bits SHALL make the pipeline empty/partially-full states explicit; bubbles SHALL propagate without corrupting adjacent results.
REQ-029 When STAGES = 1, the block SHALL register a full WIDTH ripple add with latency 1.
REQ-030 Results SHALL emerge in acceptance order; none SHALL be dropped or duplicated.

Reset
REQ-031 When rst = 1 at a clock edge, all valid bits SHALL clear, o_valid SHALL be 0, and o_sum and o_ovf SHALL be 0, regardless of en.
REQ-032 Operations in flight during reset SHALL be discarded; none SHALL appear after reset deasserts.
REQ-033 While rst = 1, o_ready SHALL be 1, but no input SHALL be captured.
REQ-034 The first input accepted after reset SHALL produce its result exactly STAGES cycles later.

Verification (WIDTH=10, STAGES=2 unless stated)
REQ-035 The bench SHALL apply a=10'h3FF, b=10'h001, i_sub=0, i_ready=1 and check that 2 cycles later o_sum=11'h400, o_ovf=0, o_valid=1.
REQ-036 The bench SHALL apply a=5, b=7, i_sub=1 and check o_sum=11'h3FE, o_ovf=0; then a=10'h1FF, b=1, i_sub=0 and check o_sum=11'h200, o_ovf=1.
REQ-037 The bench SHALL apply 8 back-to-back random operations with i_ready=1 and check 8 consecutive o_valid cycles, in order, each matching a reference model.
REQ-038 The bench SHALL hold i_ready=0 for 3 cycles with the pipeline full and check that o_sum stays constant, o_ready=0 and no input is consumed; after i_ready rises, it SHALL check that all results drain in order.
REQ-039 The bench SHALL assert rst for 1 cycle with 2 operations in flight and check that o_valid=0 and o_sum=0 the next cycle and that no stale result appears later.
REQ-040 The bench SHALL sweep WIDTH=7, STAGES in {1,3,7} with random add/sub and check carry, overflow and latency against the model.
